// File: rtl/mult_pkg.sv
// Shared types, limits and the result-selection helper for pipelined_multiplier.
// The optional word-op support is controlled by PIPELINED_MULTIPLIER_WORD_OPS_EN
// in the top level; this package is identical in both builds.
package mult_pkg;

    localparam int MULT_MAX_STAGES  = 4;
    localparam int MULT_MAX_XLEN    = 64;
    localparam int MULT_MAX_ID_BITS = 16;
    localparam int MULT_PROD_BITS   = 2 * MULT_MAX_XLEN + 2;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        MULW   = 3'd4
    } mult_op_e;

    // Which slice of the stored product the last stage presents.
    typedef enum logic [1:0] {
        SEL_LO   = 2'd0,
        SEL_HI   = 2'd1,
        SEL_ZERO = 2'd2
    } mult_sel_e;

    // One pipeline slot. Fields are sized for the widest configuration;
    // narrower builds simply leave the upper bits at zero.
    typedef struct packed {
        logic                        valid;
        logic [MULT_MAX_ID_BITS-1:0] trans_id;
        mult_op_e                    op;
        mult_sel_e                   sel;
        logic [MULT_PROD_BITS-1:0]   product;
    } mult_stage_t;

    // Word ops store an already sign-extended 64-bit value, so they read the low slice.
    function automatic mult_sel_e mult_select(input mult_op_e op, input logic word_en);
        case (op)
            MUL:                  return SEL_LO;
            MULH, MULHSU, MULHU:  return SEL_HI;
            MULW:                 return word_en ? SEL_LO : SEL_ZERO;
            default:              return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// Single pipeline register slot for pipelined_multiplier: holds on stall,
// drops its valid bit on flush (flush wins over stall), clears on reset.
module mult_pipe_stage
    import mult_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_flush,
    input  mult_stage_t i_d,
    output mult_stage_t o_q
);

    mult_stage_t r_q;

    // Slot register: reset > flush > advance; otherwise hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q.valid <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined RISC-V M-extension multiplier with valid/ready backpressure and
// a transaction tag carried alongside each operation.
// Optional macro PIPELINED_MULTIPLIER_WORD_OPS_EN enables MULW (XLEN=64 only).
module pipelined_multiplier
    import mult_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 4,
    parameter int NUM_STAGES    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     mult_valid_i,
    output logic                     mult_ready_o,
    input  mult_op_e                 operator_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] mult_trans_id_o
);

    if (NUM_STAGES < 1 || NUM_STAGES > MULT_MAX_STAGES) begin : g_bad_stages
        $error("pipelined_multiplier: NUM_STAGES must be 1..%0d", MULT_MAX_STAGES);
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("pipelined_multiplier: XLEN must be 32 or 64");
    end
    if (TRANS_ID_BITS < 1 || TRANS_ID_BITS > MULT_MAX_ID_BITS) begin : g_bad_id
        $error("pipelined_multiplier: TRANS_ID_BITS must be 1..%0d", MULT_MAX_ID_BITS);
    end

`ifdef PIPELINED_MULTIPLIER_WORD_OPS_EN
    localparam logic WORD_EN = (XLEN == 64);
    logic [31:0] w_word_lo;
    assign w_word_lo = operand_a_i[31:0] * operand_b_i[31:0];
`else
    localparam logic WORD_EN = 1'b0;
`endif

    logic                     w_a_signed;
    logic                     w_b_signed;
    logic [XLEN:0]            w_a_ext;
    logic [XLEN:0]            w_b_ext;
    logic signed [2*XLEN+1:0] w_a_wide;
    logic signed [2*XLEN+1:0] w_b_wide;
    logic signed [2*XLEN+1:0] w_prod;
    logic                     w_stall;
    logic                     w_enable;
    mult_stage_t              w_stage_in;
    mult_stage_t              w_stage [NUM_STAGES];
    mult_stage_t              w_last;
    logic [XLEN-1:0]          w_result;
    logic                     w_unused;

    // A is signed for MULH/MULHSU, B only for MULH; one extra bit keeps
    // unsigned operands positive inside a single signed multiply.
    assign w_a_signed = (operator_i == MULH) || (operator_i == MULHSU);
    assign w_b_signed = (operator_i == MULH);
    assign w_a_ext    = {w_a_signed & operand_a_i[XLEN-1], operand_a_i};
    assign w_b_ext    = {w_b_signed & operand_b_i[XLEN-1], operand_b_i};
    assign w_a_wide   = $signed({{(XLEN+1){w_a_ext[XLEN]}}, w_a_ext});
    assign w_b_wide   = $signed({{(XLEN+1){w_b_ext[XLEN]}}, w_b_ext});
    assign w_prod     = w_a_wide * w_b_wide;

    assign w_last   = w_stage[NUM_STAGES-1];
    assign w_stall  = w_last.valid && !result_ready_i;
    assign w_enable = !w_stall;
    assign mult_ready_o = !w_stall;

    // Stage-0 payload: full product plus the tag and selection it must travel with.
    always_comb begin
        w_stage_in          = '0;
        w_stage_in.valid    = mult_valid_i && mult_ready_o;
        w_stage_in.trans_id = MULT_MAX_ID_BITS'(trans_id_i);
        w_stage_in.op       = operator_i;
        w_stage_in.sel      = mult_select(operator_i, WORD_EN);
        w_stage_in.product  = MULT_PROD_BITS'(w_prod);
`ifdef PIPELINED_MULTIPLIER_WORD_OPS_EN
        if (WORD_EN && operator_i == MULW) begin
            w_stage_in.product = MULT_PROD_BITS'({{32{w_word_lo[31]}}, w_word_lo});
        end
`endif
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            mult_pipe_stage u_stage (
                .i_clk   (clk_i),
                .i_rst   (rst_i),
                .i_en    (w_enable),
                .i_flush (flush_i),
                .i_d     (w_stage_in),
                .o_q     (w_stage[g])
            );
        end else begin : g_next
            mult_pipe_stage u_stage (
                .i_clk   (clk_i),
                .i_rst   (rst_i),
                .i_en    (w_enable),
                .i_flush (flush_i),
                .i_d     (w_stage[g-1]),
                .o_q     (w_stage[g])
            );
        end
    end

    // Last stage picks the product slice straight onto the outputs.
    always_comb begin
        w_result = '0;
        case (w_last.sel)
            SEL_LO:  w_result = w_last.product[XLEN-1:0];
            SEL_HI:  w_result = w_last.product[2*XLEN-1:XLEN];
            default: w_result = '0;
        endcase
    end

    assign result_valid_o  = w_last.valid;
    assign result_o        = w_result;
    assign mult_trans_id_o = w_last.trans_id[TRANS_ID_BITS-1:0];

    // Upper product/tag bits and the carried opcode are not needed at the output.
    assign w_unused = ^w_last;

endmodule

// File: doc/pipelined_multiplier.md
Name: pipelined_multiplier

Overview:
- Parametrised successor to the single-cycle integer multiplier in the execute stage.
- Configurable pipeline depth, full RISC-V M-extension multiply set (MUL/MULH/MULHSU/MULHU) and output backpressure via a valid/ready handshake.
- Carries a transaction ID in lockstep with each operation so writeback can match results to scoreboard entries.
- Sits between issue and the writeback arbiter.

Parameters:
- XLEN, 64, operand/result width (32 or 64).
- TRANS_ID_BITS, 4, transaction ID width.
- NUM_STAGES, 2, pipeline register stages (1..4); equals latency with no stall.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill all in-flight operations.
- mult_valid_i  in  1  operation request.
- mult_ready_o  out  1  block can accept a request this cycle.
- operator_i  in  3  mult_pkg::mult_op_e (MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4).
- operand_a_i  in  XLEN  rs1 value.
- operand_b_i  in  XLEN  rs2 value.
- trans_id_i  in  TRANS_ID_BITS  scoreboard tag.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  writeback accepts result.
- result_o  out  XLEN  selected product bits.
- mult_trans_id_o  out  TRANS_ID_BITS  tag of the result.

Behaviour:
- Reset (async, rst_i=1):
  - all stage valid bits clear immediately.
  - result_valid_o=0, result_o=0, mult_trans_id_o=0, mult_ready_o=1.
  - Reset mid-operation discards every in-flight op; no result emerges after release.
- Transfer rules:
  - Input transfer occurs when mult_valid_i && mult_ready_o.
  - Output transfer occurs when result_valid_o && result_ready_i.
- Arithmetic, stage 0 (combinational into the first register):
  - Extend each operand to XLEN+1 bits: a signed for MULH/MULHSU, zero-extended otherwise; b signed for MULH only.
  - Form a 2*XLEN+2-bit signed product.
- Result selection, in the last stage:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - Operator and selection flags travel with the data.
- Pipeline:
  - NUM_STAGES register stages, each holding valid, tag, op and partial/full product.
  - The final stage drives the outputs directly, no extra register.
- Stall (global): stall = result_valid_o && !result_ready_i.
  - While stalled, every stage holds and mult_ready_o=0.
  - mult_ready_o is otherwise 1; combinational from result_ready_i and the last-stage valid.
  - Bubbles are not compressed.
- Latency: exactly NUM_STAGES cycles from input transfer to result_valid_o with no stall.
  - Throughput is 1 op/cycle; results are in-order.
- Output stability: result_o and mult_trans_id_o are stable while result_valid_o && !result_ready_i.
- Flush (flush_i=1):
  - All valid bits clear at the next edge.
  - The same-cycle input is discarded even if handshaken.
  - A same-cycle output transfer still completes.
  - Flush overrides stall.
- Unknown operator codes (5..7): result 0, valid and tag still delivered.
- NUM_STAGES outside 1..4: elaboration error via $error in a generate check.

Optional Feature:
- Macro PIPELINED_MULTIPLIER_WORD_OPS_EN; meaningful for XLEN=64 only.
- Defined:
  - MULW multiplies operand_a_i[31:0] by operand_b_i[31:0].
  - Result is the low 32 product bits, sign-extended to 64.
- Undefined: MULW is treated as an unknown operator (result 0), and the word-op logic is absent.

Decomposition:
- Package mult_pkg:
  - mult_op_e enum (3-bit).
  - Stage struct (valid, trans_id, op, product).
  - Constants MULT_MAX_STAGES=4 and the selection helper function.
- One natural sub-module: mult_pipe_stage.
  - Register stage with enable/flush and an asynchronous reset.
  - Instantiated NUM_STAGES times in a generate loop.

Test Plan:
- MUL basic: XLEN=64, NUM_STAGES=2, MUL 10*10 tag 3, ready held 1 -> result_valid_o exactly 2 cycles later, result_o=100, mult_trans_id_o=3.
- High halves:
  - MULHU 0xFFFF_FFFF_FFFF_FFFF * same -> 0xFFFF_FFFF_FFFF_FFFE.
  - MULH -1*-1 -> 0.
  - MULHSU -1 * 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: 4 back-to-back MULs (tags 0..3, a=1..4, b=5), result_ready_i low 3 cycles after the first result -> mult_ready_o low during stall, outputs frozen at tag 0/5, then 5,10,15,20 delivered in order, none lost or duplicated.
- Flush: issue tags 1,2, assert flush_i the cycle after tag 2 is accepted -> result_valid_o stays 0 for 6 cycles; next op tag 7 returns normally after 2 cycles.
- Word op:
  - With PIPELINED_MULTIPLIER_WORD_OPS_EN, MULW 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - Without the macro -> result 0, tag preserved.
- Async reset: assert rst_i mid-cycle with 2 ops in flight -> result_valid_o drops immediately, mult_ready_o=1, no result after release.
